fifo_thresh: RTL and testbench
==============================

Name: fifo_thresh

Overview:
- Single-clock FIFO with programmable almost-empty/almost-full thresholds.
- Sits directly downstream of the flow-control state machine. It consumes that machine's active-low reset_out and its latched 3-bit limit_low_out/limit_high_out.
- Its empty output is one input term of the controller's emptys, which is the AND of the empty flags of all lane FIFOs.
- Buffers data words between the lane producer and consumer, and reports occupancy status for flow control.

Parameters:
- DATA_W, 6: data word width in bits.
- DEPTH, 8: number of entries; must be a power of two, maximum 8 so the 3-bit limits cover the range.
- PTR_W, 3: pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous active-low reset; driven by the controller's reset_out.
- push  in  1  write request.
- data_in  in  DATA_W  write data.
- pop  in  1  read request.
- limit_low  in  3  almost-empty threshold.
- limit_high  in  3  almost-full threshold.
- data_out  out  DATA_W  read data, registered.
- valid_out  out  1  data_out holds a word popped in the previous cycle.
- empty  out  1  occupancy == 0.
- full  out  1  occupancy == DEPTH.
- almost_empty  out  1  low-occupancy warning.
- almost_full  out  1  high-occupancy warning.
- overflow  out  1  push rejected.
- underflow  out  1  pop rejected.

Behaviour:
- Interface: reset is synchronous, active-low; clock is clk.
- Reset: sampled only on the clk edge while reset == 0. It clears wr_ptr, rd_ptr, count, data_out, valid_out, overflow and underflow to 0. Memory contents are not cleared.
- Flags after reset: empty = 1, full = 0, almost_full = 0 (unless limit_high == 0 is ever redefined), almost_empty = 1.
- Reset asserted mid-operation: all buffered words are discarded in that cycle; no partial pop is delivered.
- State: count is PTR_W+1 bits, range 0..DEPTH. wr_ptr and rd_ptr are PTR_W bits and wrap modulo DEPTH with no special-case logic.
- Accepted write: push & (!full | pop_ok).
  - Writes data_in at wr_ptr.
  - wr_ptr increments.
- Accepted read: pop_ok = pop & !empty.
  - Next cycle: data_out = mem[rd_ptr] and valid_out = 1.
  - rd_ptr increments.
  - Read latency is 1 cycle.
- Idle or rejected read: valid_out = 0 the next cycle and data_out holds its previous value.
- count update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged when both are accepted or neither is.
- Simultaneous push & pop while full: both accepted, count stays at DEPTH, no overflow.
- Simultaneous push & pop while empty: push accepted; the pop is rejected as an underflow. There is no fall-through path.
- Rejected write: push & full & !pop.
  - Word dropped, state unchanged.
  - overflow = 1 on the next cycle.
- Rejected read: pop & empty.
  - underflow = 1 on the next cycle.
- Without the optional feature, overflow and underflow are single-cycle pulses per rejected request.
- empty and full: combinational from count.
- almost_empty: (count <= limit_low). With limit_low = 0 it equals empty.
- almost_full: (limit_high != 0) & (count >= limit_high). limit_high = 0 disables the flag.
- Limits are used combinationally every cycle; the controller holds them stable outside its INIT state.

Optional Feature:
- Macro: FIFO_ERR_STICKY_EN.
- Defined: overflow and underflow are sticky. Once set, each stays 1 until the next reset cycle.
- Not defined: each flag is a 1-cycle pulse per rejected request.
- No other behaviour differs between the two builds.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_W, DEPTH and PTR_W defaults.
  - LIMIT_W = 3.
  - A typedef for the data word.
  - A typedef for count (PTR_W+1 bits).
- The controller uses the same LIMIT_W constant.
- One sub-module, fifo_mem: a DEPTH x DATA_W register file with a synchronous write port and a registered read port (rd_en, rd_addr).
- fifo_thresh holds the pointers, count, flags and error logic.

Test Plan:
- Reset behaviour: drive reset = 0 for 2 cycles with push = 1 → empty = 1, full = 0, valid_out = 0, count = 0, no write recorded.
- Fill and drain: push 8 words 0x01..0x08, then pop 8 → full asserts after the 8th push; data_out = 0x01..0x08 in order, each one cycle after its pop; empty = 1 at the end.
- Thresholds: with limit_low = 2 and limit_high = 6, push one word at a time → almost_empty = 1 at counts 0..2 and 0 at 3; almost_full = 0 at 5 and 1 at 6. Repeat with limit_high = 0 → almost_full stays 0 even when full.
- Simultaneous push/pop:
  - When full: push 0x2A with pop → count stays 8, no overflow, head word popped.
  - When empty: push and pop together → count becomes 1, underflow = 1 next cycle.
- Error flags: push when full without pop, then pop when empty → overflow and underflow each pulse for 1 cycle. Under FIFO_ERR_STICKY_EN both stay 1 until reset = 0.
- Wrap-around and mid-operation reset: run 20 push/pop cycles at occupancy 3 so both pointers wrap twice, checking data order throughout. Then assert reset with count = 3 → empty = 1 the next cycle and no stale valid_out.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and types for the lane FIFO and its flow-control
// controller.
//
// Contents:
//   DEF_DATA_W  default data word width (6)
//   DEF_DEPTH   default number of entries (8, power of two, at most 8)
//   DEF_PTR_W   default pointer width, log2(DEF_DEPTH) (3)
//   LIMIT_W     width of the almost-empty/almost-full thresholds (3); the
//               controller sizes its latched limits with the same constant
//   data_t      one data word at the default width
//   count_t     occupancy at the default depth, 0..DEF_DEPTH (DEF_PTR_W+1 bits)

package fifo_pkg;

    localparam int unsigned DEF_DATA_W = 6;
    localparam int unsigned DEF_DEPTH  = 8;
    localparam int unsigned DEF_PTR_W  = 3;
    localparam int unsigned LIMIT_W    = 3;

    typedef logic [DEF_DATA_W-1:0] data_t;
    typedef logic [DEF_PTR_W:0]    count_t;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_W register file used as FIFO storage.
//
// The write port is synchronous. The read port is registered: when rd_en is
// high the word at rd_addr appears on rd_data after the next rising edge,
// otherwise rd_data holds its value. Only the read register is reset; the
// array contents survive reset.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-low reset (clears rd_data only)
//   wr_en    in   write strobe
//   wr_addr  in   PTR_W  write address
//   wr_data  in   DATA_W write data
//   rd_en    in   read strobe
//   rd_addr  in   PTR_W  read address
//   rd_data  out  DATA_W registered read data

module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned PTR_W  = DEF_PTR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // A read of the slot being written in the same cycle returns the old word,
    // which is what the full-FIFO simultaneous push/pop case relies on.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_thresh.sv
// fifo_thresh: single-clock lane FIFO with programmable almost-empty and
// almost-full thresholds, placed downstream of the flow-control controller.
//
// Build option: define FIFO_ERR_STICKY_EN to make overflow/underflow sticky
// until the next reset cycle; otherwise each is a one-cycle pulse per
// rejected request.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   synchronous active-low reset (controller's reset_out)
//   push          in   write request
//   data_in       in   DATA_W write data
//   pop           in   read request
//   limit_low     in   LIMIT_W almost-empty threshold
//   limit_high    in   LIMIT_W almost-full threshold (0 disables the flag)
//   data_out      out  DATA_W registered read data
//   valid_out     out  data_out holds a word popped in the previous cycle
//   empty         out  occupancy == 0
//   full          out  occupancy == DEPTH
//   almost_empty  out  occupancy <= limit_low
//   almost_full   out  limit_high != 0 and occupancy >= limit_high
//   overflow      out  a push was rejected
//   underflow     out  a pop was rejected

module fifo_thresh
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned PTR_W  = DEF_PTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               pop,
    input  logic [LIMIT_W-1:0] limit_low,
    input  logic [LIMIT_W-1:0] limit_high,
    output logic [DATA_W-1:0]  data_out,
    output logic               valid_out,
    output logic               empty,
    output logic               full,
    output logic               almost_empty,
    output logic               almost_full,
    output logic               overflow,
    output logic               underflow
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             wr_ok;
    logic             rd_ok;
    logic             overflow_evt;
    logic             underflow_evt;

    // ------------------------------------------------------------------
    // Occupancy status, purely from the registered count
    // ------------------------------------------------------------------
    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    assign almost_empty = (count_q <= CNT_W'(limit_low));
    assign almost_full  = (limit_high != '0) && (count_q >= CNT_W'(limit_high));

    // ------------------------------------------------------------------
    // Request acceptance
    // ------------------------------------------------------------------
    // A pop while full frees a slot in the same cycle, so the paired push is
    // still accepted. There is no fall-through: a push into an empty FIFO
    // cannot satisfy a pop in the same cycle.
    assign rd_ok         = pop && !empty;
    assign wr_ok         = push && (!full || rd_ok);
    assign overflow_evt  = push && full && !pop;
    assign underflow_evt = pop && empty;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Pointers are PTR_W bits wide and wrap naturally at DEPTH.
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        valid_d = rd_ok;
    end

    always_comb begin
`ifdef FIFO_ERR_STICKY_EN
        overflow_d  = overflow_q  || overflow_evt;
        underflow_d = underflow_q || underflow_evt;
`else
        overflow_d  = overflow_evt;
        underflow_d = underflow_evt;
`endif
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign valid_out = valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // Writes are blocked during reset so a push in a reset cycle leaves no
    // trace; the read register is cleared by reset inside fifo_mem.
    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok && reset),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr_q),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_fifo_thresh.sv
// tb_fifo_thresh: self-checking bench for fifo_thresh. A queue-based model of
// the FIFO runs alongside the DUT and every output is compared on each falling
// edge; directed phases add hand-computed expectations. Honours
// FIFO_ERR_STICKY_EN the same way the design does.

module tb_fifo_thresh;
    import fifo_pkg::*;

    localparam int DW    = DEF_DATA_W;
    localparam int DEPTH = DEF_DEPTH;
`ifdef FIFO_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [2:0]    limit_low;
    logic [2:0]    limit_high;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fifo_thresh dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .limit_low    (limit_low),
        .limit_high   (limit_high),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: contents as a queue, outputs from its size
    // ------------------------------------------------------------------
    data_t   m_q[$];
    data_t   m_data  = '0;
    bit      m_valid = 1'b0;
    bit      m_ovf   = 1'b0;
    bit      m_unf   = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            m_q.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            int  n;
            bit  was_empty, was_full, pop_ok, push_ok, ov, un;
            n         = m_q.size();
            was_empty = (n == 0);
            was_full  = (n == DEPTH);
            pop_ok    = pop && !was_empty;
            push_ok   = push && (!was_full || pop_ok);
            ov        = push && was_full && !pop;
            un        = pop && was_empty;
            if (pop_ok) begin
                m_data  = m_q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (push_ok) m_q.push_back(data_in);
            m_ovf = STICKY ? (m_ovf || ov) : ov;
            m_unf = STICKY ? (m_unf || un) : un;
        end
    end

    // One compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            int n;
            n = m_q.size();
            check("cmp_empty", empty, n == 0);
            check("cmp_full", full, n == DEPTH);
            check("cmp_almost_empty", almost_empty, n <= int'(limit_low));
            check("cmp_almost_full", almost_full, (limit_high != 0) && (n >= int'(limit_high)));
            check("cmp_valid_out", valid_out, m_valid);
            check("cmp_data_out", data_out, m_data);
            check("cmp_overflow", overflow, m_ovf);
            check("cmp_underflow", underflow, m_unf);
        end
    end

    // Inputs change 2 time units after a rising edge; the next edge applies them.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Expected flag patterns for counts 0..8 with limit_low=2, limit_high=6.
    logic [8:0]    ae_tab = 9'b000000111;
    logic [8:0]    af_tab = 9'b111000000;
    logic [DW-1:0] drain_tab [8] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h2A};

    initial begin
        reset      = 1'b0;
        push       = 1'b1;
        data_in    = 6'h3F;
        pop        = 1'b0;
        limit_low  = 3'd2;
        limit_high = 3'd6;

        // Reset with push held: nothing may be recorded.
        tick;
        chk_en = 1'b1;
        tick;
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_valid", valid_out, 1'b0);
        check("rst_almost_empty", almost_empty, 1'b1);
        check("rst_almost_full", almost_full, 1'b0);
        check("rst_data_out", data_out, 6'h00);
        reset = 1'b1;
        push  = 1'b0;
        tick;
        check("rst_no_write", empty, 1'b1);

        // Fill one word at a time, checking thresholds at every count.
        check("thr_ae_c0", almost_empty, ae_tab[0]);
        check("thr_af_c0", almost_full, af_tab[0]);
        for (int i = 1; i <= 8; i++) begin
            push = 1'b1; data_in = DW'(i);
            tick;
            push = 1'b0;
            check($sformatf("thr_ae_c%0d", i), almost_empty, ae_tab[i]);
            check($sformatf("thr_af_c%0d", i), almost_full, af_tab[i]);
            check($sformatf("fill_full_c%0d", i), full, i == 8);
        end

        // Drain: each word appears one cycle after its pop.
        for (int i = 1; i <= 8; i++) begin
            pop = 1'b1;
            tick;
            check($sformatf("drain_data_%0d", i), data_out, DW'(i));
            check($sformatf("drain_valid_%0d", i), valid_out, 1'b1);
        end
        pop = 1'b0;
        tick;
        check("drain_empty", empty, 1'b1);
        check("drain_valid_off", valid_out, 1'b0);
        check("drain_data_hold", data_out, 6'h08);

        // limit_high = 0 disables almost_full even when full.
        limit_high = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            push = 1'b1; data_in = DW'(i);
            tick;
            check($sformatf("af_off_c%0d", i), almost_full, 1'b0);
        end
        check("af_off_full", full, 1'b1);

        // Full: push with pop keeps count at DEPTH, returns the head.
        push = 1'b1; pop = 1'b1; data_in = 6'h2A;
        tick;
        check("fullpp_full", full, 1'b1);
        check("fullpp_ovf", overflow, 1'b0);
        check("fullpp_data", data_out, 6'h01);
        check("fullpp_valid", valid_out, 1'b1);

        // Full: push without pop is dropped.
        pop = 1'b0; data_in = 6'h3C;
        tick;
        push = 1'b0;
        check("ovf_pulse", overflow, 1'b1);
        check("ovf_valid", valid_out, 1'b0);
        tick;
        check("ovf_after", overflow, STICKY);
        check("ovf_still_full", full, 1'b1);

        for (int i = 0; i < 8; i++) begin
            pop = 1'b1;
            tick;
            check($sformatf("drain2_%0d", i), data_out, drain_tab[i]);
        end

        // Empty: push with pop accepts the push, rejects the pop.
        push = 1'b1; data_in = 6'h15;
        tick;
        push = 1'b0; pop = 1'b0;
        check("emptypp_unf", underflow, 1'b1);
        check("emptypp_empty", empty, 1'b0);
        check("emptypp_valid", valid_out, 1'b0);
        tick;
        check("unf_after", underflow, STICKY);
        check("unf_ovf_after", overflow, STICKY);
        pop = 1'b1;
        tick;
        pop = 1'b0;
        check("emptypp_word", data_out, 6'h15);
        reset = 1'b0;
        tick;
        reset = 1'b1;
        check("errs_clear_ovf", overflow, 1'b0);
        check("errs_clear_unf", underflow, 1'b0);

        // Wrap-around at occupancy 3, then reset mid-operation.
        limit_high = 3'd6;
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; data_in = DW'(8'h10 + i);
            tick;
        end
        pop = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = DW'(8'h13 + i);
            tick;
            check($sformatf("wrap_data_%0d", i), data_out, DW'(8'h10 + i));
            check($sformatf("wrap_ae_%0d", i), almost_empty, 1'b0);
        end
        push  = 1'b0;
        reset = 1'b0;
        tick;
        check("midrst_empty", empty, 1'b1);
        check("midrst_valid", valid_out, 1'b0);
        reset = 1'b1;
        pop   = 1'b0;
        tick;
        check("midrst_valid2", valid_out, 1'b0);
        check("midrst_empty2", empty, 1'b1);

        // Randomised traffic with phases biased toward filling or draining.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = (i / 64) % 3;
            if (i % 32 == 0) begin
                limit_low  = 3'($urandom_range(0, 7));
                limit_high = 3'($urandom_range(0, 7));
            end
            push    = ($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 2 : 5)));
            pop     = ($urandom_range(0, 9) < (bias == 0 ? 2 : (bias == 1 ? 8 : 5)));
            data_in = DW'($urandom);
            reset   = ($urandom_range(0, 199) != 0);
            tick;
        end

        reset = 1'b1; push = 1'b0; pop = 1'b0;
        tick;
        tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
